// File: rtl/fios_result_collector_if.sv
// Interface bundling the result-word stream, the result handshake and the
// status outputs of fios_result_collector.
//   slave  : the collector itself
//   master : the side that drives pushes, start and ready (PE cascade / host)
interface fios_result_collector_if #(
  parameter int s = 16,
  parameter int W = 17
);
  logic           start_i;
  logic           res_push_i;
  logic [W:0]     res_word_i;
  logic [s*W-1:0] res_o;
  logic [1:0]     res_carry_o;
  logic           res_valid_o;
  logic           res_ready_i;
  logic           busy_o;
  logic           overflow_err_o;

  modport slave (
    input  start_i, res_push_i, res_word_i, res_ready_i,
    output res_o, res_carry_o, res_valid_o, busy_o, overflow_err_o
  );

  modport master (
    output start_i, res_push_i, res_word_i, res_ready_i,
    input  res_o, res_carry_o, res_valid_o, busy_o, overflow_err_o
  );
endinterface

// File: rtl/fios_result_collector.sv
// fios_result_collector
//   Tail-end receiver of the FIOS PE cascade. Absorbs the RES_push word
//   stream leaving the last PE (LSW first), assembles s words of W bits into
//   one registered s*W-bit result and hands it off via valid/ready.
//
//   Optional feature macro: FIOS_RES_CARRY_NORM_EN
//     defined   : each incoming word (W+1 bits incl. PE carry-out) is added to
//                 a running 2-bit carry; the slot keeps the low W bits and the
//                 carry after the last word is presented on res_carry_o.
//     undefined : words are stored as-is (bit W ignored), res_carry_o = 0.
module fios_result_collector #(
  parameter int s = 16,
  parameter int W = 17
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  fios_result_collector_if.slave    bus
);

  // Counter width; a single-word result still needs one bit to keep the
  // arithmetic legal.
  localparam int CNT_W = (s > 1) ? $clog2(s) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [s*W-1:0]   res_q;
  logic             ovf_q;

  logic             in_idle, in_collect, in_hold;
  logic             handshake;
  logic             arm;        // start that (re)opens a collection
  logic             accept;     // push that lands in a slot this cycle
  logic             last_word;  // accepted push fills the final slot
  logic [W-1:0]     slot_d;

  assign in_idle    = (state_q == ST_IDLE);
  assign in_collect = (state_q == ST_COLLECT);
  assign in_hold    = (state_q == ST_HOLD);

  assign handshake  = in_hold & bus.res_ready_i;

  // A start is honoured anywhere except while a result is held and not yet
  // taken; in HOLD it only counts together with the handshake.
  assign arm        = bus.start_i & (~in_hold | bus.res_ready_i);

  // A start in COLLECT aborts, so a push in the same cycle is discarded.
  assign accept     = in_collect & bus.res_push_i & ~bus.start_i;
  assign last_word  = accept & (word_cnt_q == CNT_W'(s - 1));

`ifdef FIOS_RES_CARRY_NORM_EN
  logic [1:0]   carry_q;
  logic [1:0]   res_carry_q;
  logic [W+1:0] sum;

  // Carry never exceeds 2, so W+2 bits hold word + carry without loss.
  assign sum    = {1'b0, bus.res_word_i} + {{W{1'b0}}, carry_q};
  assign slot_d = sum[W-1:0];

  // Running carry: cleared whenever a collection is (re)opened.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)  carry_q <= 2'b00;
    else if (arm)    carry_q <= 2'b00;
    else if (accept) carry_q <= sum[W+1:W];
  end

  // Final carry is captured only when the result becomes complete.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)     res_carry_q <= 2'b00;
    else if (last_word) res_carry_q <= sum[W+1:W];
  end

  assign bus.res_carry_o = res_carry_q;
`else
  logic word_msb_unused;

  // The PE carry-out bit has no consumer without normalisation.
  assign word_msb_unused = bus.res_word_i[W];
  assign slot_d          = bus.res_word_i[W-1:0];
  assign bus.res_carry_o = 2'b00;
`endif

  // Control FSM: IDLE -> COLLECT on start, COLLECT -> HOLD on the s-th word,
  // HOLD -> IDLE (or straight back to COLLECT) on the handshake.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_q    <= ST_COLLECT;
            word_cnt_q <= '0;
          end
        end
        ST_COLLECT: begin
          if (bus.start_i) begin
            word_cnt_q <= '0;
          end else if (bus.res_push_i) begin
            // Counter parks at s-1 on the last word instead of wrapping.
            if (last_word) state_q    <= ST_HOLD;
            else           word_cnt_q <= word_cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            word_cnt_q <= '0;
            state_q    <= bus.start_i ? ST_COLLECT : ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          word_cnt_q <= '0;
        end
      endcase
    end
  end

  // Slot write: the accepted word goes to the slot addressed by word_cnt.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      res_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < s; k++) begin
        if (word_cnt_q == CNT_W'(k)) res_q[k*W +: W] <= slot_d;
      end
    end
  end

  // Sticky error: a push arrived while no slot was open (IDLE or HOLD).
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)                                ovf_q <= 1'b0;
    else if (bus.res_push_i && (in_idle || in_hold)) ovf_q <= 1'b1;
  end

  assign bus.res_o          = res_q;
  assign bus.res_valid_o    = in_hold;
  assign bus.busy_o         = in_collect;
  assign bus.overflow_err_o = ovf_q;

endmodule
